// File: rtl/step_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : step_debouncer
//  Description : Conditions the raw active-low single-step push-button.
//                It synchronises the pin and debounces it into a one-cycle
//                strobe that advances the PC. It also exports the debounced
//                level and a wrapping count of accepted pulses.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE_CYCLES     stable cycles needed to accept a level change (>= 2)
//    REPEAT_DELAY_CYCLES held time before the first auto-repeat pulse
//    REPEAT_RATE_CYCLES  spacing between later auto-repeat pulses
//    CNT_W               width of press_count
//  Ports
//    clk           in   system clock
//    reset         in   asynchronous reset, active low
//    button        in   raw button, active low, asynchronous to clk
//    button_pulse  out  one-cycle strobe per accepted press / repeat
//    button_level  out  debounced state, 1 = pressed
//    press_count   out  number of accepted pulses, wraps modulo 2^CNT_W
//  Build option
//    STEP_DEBOUNCE_AUTOREPEAT_EN : when defined, a held button auto-repeats
// ============================================================================
module step_debouncer #(
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000,
    parameter int CNT_W               = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button,
    output logic             button_pulse,
    output logic             button_level,
    output logic [CNT_W-1:0] press_count
);

    localparam int MAX_DR   = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                              DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int MAX_ALL  = (MAX_DR > REPEAT_RATE_CYCLES) ? MAX_DR : REPEAT_RATE_CYCLES;
    localparam int CNT_BITS = $clog2(MAX_ALL + 1);

    localparam logic [CNT_BITS-1:0] DB_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [1:0]          sync_q,   sync_d;
    logic [1:0]          warm_q,   warm_d;
    logic                armed_q,  armed_d;
    logic [CNT_BITS-1:0] cnt_q,    cnt_d;
    logic                pulse_q,  pulse_d;
    logic                level_q,  level_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic                s;

`ifdef STEP_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_BITS-1:0] DELAY_LAST = CNT_BITS'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] RATE_LAST  = CNT_BITS'(REPEAT_RATE_CYCLES - 1);
    // Set once the first repeat has fired; later repeats use the faster rate.
    logic                rep_q,    rep_d;
`endif

    always_comb begin
        // sync_q[0] is the first synchroniser stage; s is the active-high level.
        s       = ~sync_q[1];
        sync_d  = {sync_q[0], button};

        // The synchroniser flops reset to "released", so s reads 0 for two
        // edges after reset regardless of the pin. warm_q marks when sync_q[1]
        // holds a real sample; presses are only accepted after a genuine
        // release has been seen, so a button held through reset never pulses.
        warm_d  = {warm_q[0], 1'b1};
        armed_d = armed_q | (warm_q[1] & ~s);

        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        count_d = count_q;
`ifdef STEP_DEBOUNCE_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif

        case (state_q)
            IDLE: begin
                if (s && armed_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    count_d = count_q + 1'b1;
                    cnt_d   = '0;
`ifdef STEP_DEBOUNCE_AUTOREPEAT_EN
                    rep_d   = 1'b0;
`endif
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = REL_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef STEP_DEBOUNCE_AUTOREPEAT_EN
                    if (cnt_q == (rep_q ? RATE_LAST : DELAY_LAST)) begin
                        pulse_d = 1'b1;
                        count_d = count_q + 1'b1;
                        cnt_d   = '0;
                        rep_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
`endif
                end
            end
            REL_CHK: begin
                if (s) begin
                    // Release was a glitch; repeat timing restarts from the
                    // initial delay.
                    state_d = HELD;
                    cnt_d   = '0;
`ifdef STEP_DEBOUNCE_AUTOREPEAT_EN
                    rep_d   = 1'b0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
`ifdef STEP_DEBOUNCE_AUTOREPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            count_q <= count_d;
`ifdef STEP_DEBOUNCE_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign button_pulse = pulse_q;
    assign button_level = level_q;
    assign press_count  = count_q;

endmodule
`default_nettype wire
